// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg: shared constants and types for the four-bank,
// word-interleaved backing memory.
//   BANK_CNT           number of banks
//   BANK_SEL_LSB/MSB   byte-address bits selecting the bank (addr[2:1])
//   IDX_LSB            lowest byte-address bit of the per-bank word index
//   CNT_W              width of each bank's busy down-counter
//   MEM_DATA_W         data width carried by the read-return pipeline
//   rd_pipe_t          one read-return pipeline entry {valid, data}
package banked_mem_pkg;

  localparam int BANK_CNT     = 4;
  localparam int BANK_SEL_LSB = 1;
  localparam int BANK_SEL_MSB = 2;
  localparam int IDX_LSB      = 3;
  localparam int CNT_W        = 3;
  localparam int MEM_DATA_W   = 16;

  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] data;
  } rd_pipe_t;

endpackage

// File: rtl/banked_mem_bank.sv
// banked_mem_bank: one memory bank with its storage array and busy counter.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset (clears the busy state only)
//   accept  request accepted into this bank this cycle
//   write   accepted request is a write (otherwise a read)
//   idx     word index within the bank
//   wdata   write data
//   busy    bank cannot accept a request this cycle
//   rdata   combinational read of storage[idx]
module banked_mem_bank
  import banked_mem_pkg::*;
#(
  parameter int DATA_W   = MEM_DATA_W,
  parameter int IDX_W    = 8,
  parameter int BUSY_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              write,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // busy_q rises on the edge after acceptance and stays up for BUSY_CYC
  // cycles: the counter holds the number of busy cycles still remaining
  // after the current one.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (accept) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(BUSY_CYC - 1);
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Storage is deliberately not reset so committed writes survive reset.
  always_ff @(posedge clk) begin
    if (accept && write) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];
  assign busy  = busy_q;

endmodule

// File: rtl/banked_mem.sv
// banked_mem: four-bank word-interleaved backing memory behind the cache
// controller. Bank = addr[2:1], word index = addr[IDX_W+2:3].
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   addr      request byte address
//   data_in   write data
//   wr, rd    write / read request strobes (exactly one for a valid request)
//   data_out  read return data, holds when rd_valid=0
//   rd_valid  data_out carries a new read return this cycle
//   stall     request present but target bank busy; not accepted
//   busy      per-bank busy flags
//   err       one-cycle pulse after an illegal request
// Handshake: a request (rd^wr) is accepted at the rising edge when its bank
// is not busy and no error applies; while stall is high the requester must
// hold the request. A read returns RD_LAT edges after acceptance.
// Optional feature macro BANKED_MEM_ALIGN_CHK_EN: when defined, odd byte
// addresses are rejected with err; otherwise addr[0] is ignored.
module banked_mem
  import banked_mem_pkg::*;
#(
  parameter int DATA_W   = MEM_DATA_W,
  parameter int ADDR_W   = 16,
  parameter int IDX_W    = 8,
  parameter int BUSY_CYC = 4,
  parameter int RD_LAT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                wr,
  input  logic                rd,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                stall,
  output logic [BANK_CNT-1:0] busy,
  output logic                err
);

  logic [1:0]          bank_sel;
  logic [IDX_W-1:0]    idx;
  logic                req_one;
  logic                req_both;
  logic                align_err;
  logic                accept;
  logic [BANK_CNT-1:0] bank_accept;
  logic [BANK_CNT-1:0] busy_w;
  logic [DATA_W-1:0]   rdata_w [BANK_CNT];
  logic [DATA_W-1:0]   rd_word;

  rd_pipe_t            pipe_q [RD_LAT];
  rd_pipe_t            pipe_d [RD_LAT];
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;

  // Address bits above the index (and addr[0] when unchecked) are ignored.
  logic                unused_addr;
  assign unused_addr = ^{addr[ADDR_W-1:IDX_LSB+IDX_W], addr[0]};

  assign bank_sel = addr[BANK_SEL_MSB:BANK_SEL_LSB];
  assign idx      = addr[IDX_LSB+IDX_W-1:IDX_LSB];
  assign req_one  = rd ^ wr;
  assign req_both = rd & wr;

`ifdef BANKED_MEM_ALIGN_CHK_EN
  assign align_err = req_one & addr[0];
`else
  assign align_err = 1'b0;
`endif

  assign stall  = req_one & busy_w[bank_sel];
  assign accept = req_one & ~busy_w[bank_sel] & ~align_err;

  always_comb begin
    bank_accept = '0;
    bank_accept[bank_sel] = accept;
  end

  for (genvar b = 0; b < BANK_CNT; b++) begin : g_bank
    banked_mem_bank #(
      .DATA_W   (DATA_W),
      .IDX_W    (IDX_W),
      .BUSY_CYC (BUSY_CYC)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .accept (bank_accept[b]),
      .write  (wr),
      .idx    (idx),
      .wdata  (data_in),
      .busy   (busy_w[b]),
      .rdata  (rdata_w[b])
    );
  end

  assign rd_word = rdata_w[bank_sel];

  // Stage 0 captures the read word at the accepting edge; the last stage
  // feeds the output register, giving RD_LAT edges to rd_valid.
  always_comb begin
    pipe_d[0].valid = accept & rd;
    pipe_d[0].data  = rd_word;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    rd_valid_d = pipe_q[RD_LAT-1].valid;
    data_out_d = data_out_q;
    if (pipe_q[RD_LAT-1].valid) begin
      data_out_d = pipe_q[RD_LAT-1].data;
    end
    err_d = req_both | align_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign busy     = busy_w;

endmodule

// File: tb/tb_banked_mem.sv
// tb_banked_mem: directed bench for banked_mem with a scoreboard queue.
// The driver pushes {due_cycle, data} on every accepted read; the monitor
// pops on every rd_valid and checks both the data and the return cycle.
module tb_banked_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              stall;
  logic [3:0]        busy;
  logic              err;

  int                cyc = 0;
  int                n_vec = 0;
  int                n_fail = 0;
  logic [31:0]       exp_q[$];

  banked_mem dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- compare helper ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
               name, act, exp_v, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got data 0x%0h expected no return at cycle %0d",
                 data_out, cyc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("rd_data", {16'h0, data_out}, {16'h0, e[15:0]});
        check("rd_cycle", 32'(cyc) & 32'hFFFF, {16'h0, e[31:16]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request, hold it through stalls, return after acceptance.
  task automatic req(input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] e_data,
                     output int stalls, output logic [3:0] busy_seen);
    rd = r; wr = w; addr = a; data_in = d;
    stalls = 0;
    @(negedge clk);
    while (stall === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    busy_seen = busy;
    if (stall === 1'b1) begin
      n_vec++;
      n_fail++;
      $display("FAIL stall_timeout: got stall held 20 cycles expected acceptance addr 0x%0h", a);
    end
    @(posedge clk);
    #1;
    if (r && !w) exp_q.push_back({16'(cyc + RD_LAT), e_data});
    rd = 1'b0; wr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    logic [3:0] b;
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_data_out", {16'h0, data_out}, 32'h0);
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_busy", {28'h0, busy}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // preload words used below
    req(1'b0, 1'b1, 16'h0102, 16'hBEEF, 16'h0, s, b);
    req(1'b0, 1'b1, 16'h0040, 16'h1111, 16'h0, s, b);
    req(1'b0, 1'b1, 16'h0042, 16'h2222, 16'h0, s, b);
    req(1'b0, 1'b1, 16'h0044, 16'h3333, 16'h0, s, b);
    req(1'b0, 1'b1, 16'h0046, 16'h4444, 16'h0, s, b);
    req(1'b0, 1'b1, 16'h0048, 16'h5555, 16'h0, s, b);
    req(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0, s, b);
    req(1'b0, 1'b1, 16'h0020, 16'h5A5A, 16'h0, s, b);
    idle(8);

    // write-then-read returns the written word RD_LAT edges later
    req(1'b1, 1'b0, 16'h0102, 16'h0, 16'hBEEF, s, b);
    check("read_nostall", 32'(s), 32'd0);
    idle(6);
    @(negedge clk);
    check("hold_data_out", {16'h0, data_out}, 32'h0000BEEF);
    check("hold_rd_valid", {31'h0, rd_valid}, 32'h0);
    @(posedge clk); #1;

    // line fill across all four banks, one word per cycle
    req(1'b1, 1'b0, 16'h0040, 16'h0, 16'h1111, s, b);
    check("fill0_stall", 32'(s), 32'd0);
    check("fill0_busy", {28'h0, b}, 32'h0);
    req(1'b1, 1'b0, 16'h0042, 16'h0, 16'h2222, s, b);
    check("fill1_stall", 32'(s), 32'd0);
    check("fill1_busy", {28'h0, b}, 32'h1);
    req(1'b1, 1'b0, 16'h0044, 16'h0, 16'h3333, s, b);
    check("fill2_stall", 32'(s), 32'd0);
    check("fill2_busy", {28'h0, b}, 32'h3);
    req(1'b1, 1'b0, 16'h0046, 16'h0, 16'h4444, s, b);
    check("fill3_stall", 32'(s), 32'd0);
    check("fill3_busy", {28'h0, b}, 32'h7);
    @(negedge clk);
    check("fill_busy_all", {28'h0, busy}, 32'hF);
    @(posedge clk); #1;
    idle(8);

    // same-bank back-to-back read: stalled for BUSY_CYC cycles
    req(1'b1, 1'b0, 16'h0040, 16'h0, 16'h1111, s, b);
    req(1'b1, 1'b0, 16'h0048, 16'h0, 16'h5555, s, b);
    check("samebank_stalls", 32'(s), 32'd4);
    idle(8);

    // rd and wr together: no access, one-cycle err pulse
    rd = 1'b1; wr = 1'b1; addr = 16'h0010; data_in = 16'hFFFF;
    @(negedge clk);
    check("both_stall", {31'h0, stall}, 32'h0);
    check("both_err_pre", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("both_err", {31'h0, err}, 32'h1);
    check("both_busy", {28'h0, busy}, 32'h0);
    @(negedge clk);
    check("both_err_clear", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    // the rejected write must not have touched 0x0010
    req(1'b1, 1'b0, 16'h0010, 16'h0, 16'h1234, s, b);
    idle(8);

    // odd byte address
`ifdef BANKED_MEM_ALIGN_CHK_EN
    rd = 1'b1; addr = 16'h0011;
    @(negedge clk);
    check("align_err_pre", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    rd = 1'b0;
    @(negedge clk);
    check("align_err", {31'h0, err}, 32'h1);
    check("align_busy", {28'h0, busy}, 32'h0);
    @(negedge clk);
    check("align_err_clear", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
`else
    req(1'b1, 1'b0, 16'h0011, 16'h0, 16'h1234, s, b);
    @(negedge clk);
    check("odd_addr_no_err", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
`endif
    idle(8);

    // reset while a read is in flight
    req(1'b1, 1'b0, 16'h0020, 16'h0, 16'h5A5A, s, b);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("midrst_busy", {28'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("postrst_rd_valid", {31'h0, rd_valid}, 32'h0);
    end
    check("postrst_busy", {28'h0, busy}, 32'h0);
    @(posedge clk); #1;
    req(1'b1, 1'b0, 16'h0020, 16'h0, 16'h5A5A, s, b);
    check("postrst_nostall", 32'(s), 32'd0);
    idle(8);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
